// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/bubble controller.
// Detects load-use hazards, hazards on operands of branches resolved in D, and
// mult/div unit occupancy. While a hazard is present it holds PC and the D
// register and puts a bubble into E. It also tracks mult/div busy time and
// counts stalled cycles.
module hazard_stall_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic        D_use_rs,
    input  logic        D_use_rt,
    input  logic        D_branch,
    input  logic        D_md_start,
    input  logic        D_md_div,
    input  logic        D_md_use,
    input  logic [4:0]  E_wa,
    input  logic        E_regwrite,
    input  logic        E_load,
    input  logic [4:0]  M_wa,
    input  logic        M_load,
    output logic        stall,
    output logic        pc_en,
    output logic        flush_E,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic match_e_rs, match_e_rt, match_m_rs, match_m_rt;
    logic ld_use, br_haz, md_haz;
    logic md_accept;

    // Register-match terms; $0 is hard-wired and never creates a dependency
    always_comb begin
        match_e_rs = (E_wa == D_rs) && (D_rs != 5'd0);
        match_e_rt = (E_wa == D_rt) && (D_rt != 5'd0);
        match_m_rs = (M_wa == D_rs) && (D_rs != 5'd0);
        match_m_rt = (M_wa == D_rt) && (D_rt != 5'd0);
    end

    // Hazard detection and the pipeline control outputs derived from it
    always_comb begin
        ld_use  = E_load && ((D_use_rs && match_e_rs) || (D_use_rt && match_e_rt));
        br_haz  = D_branch && ((E_regwrite && (match_e_rs || match_e_rt)) ||
                               (M_load && (match_m_rs || match_m_rt)));
        md_busy = (cnt_q != '0) && !reset;
        md_haz  = D_md_use && md_busy;
        stall   = (ld_use || br_haz || md_haz) && !reset;
        pc_en   = !stall;
        flush_E = stall;
        // A start held by any stall is simply retried once the stall clears
        md_accept = D_md_start && !stall;
    end

    // Next state of the mult/div busy countdown
    always_comb begin
        cnt_d = cnt_q;
        if (md_accept) begin
            cnt_d = D_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Next state of the saturating stall-cycle counter
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State registers; reset aborts any countdown in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed test of hazard_stall_ctrl with hand-computed expected values.
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  D_rs, D_rt, E_wa, M_wa;
    logic        D_use_rs, D_use_rt, D_branch, D_md_start, D_md_div, D_md_use;
    logic        E_regwrite, E_load, M_load;
    logic        stall, pc_en, flush_E, md_busy;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    hazard_stall_ctrl #(
        .MULT_LAT(5),
        .DIV_LAT (10),
        .CNT_W   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .D_use_rs  (D_use_rs),
        .D_use_rt  (D_use_rt),
        .D_branch  (D_branch),
        .D_md_start(D_md_start),
        .D_md_div  (D_md_div),
        .D_md_use  (D_md_use),
        .E_wa      (E_wa),
        .E_regwrite(E_regwrite),
        .E_load    (E_load),
        .M_wa      (M_wa),
        .M_load    (M_load),
        .stall     (stall),
        .pc_en     (pc_en),
        .flush_E   (flush_E),
        .md_busy   (md_busy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        D_rs = '0; D_rt = '0; D_use_rs = 0; D_use_rt = 0; D_branch = 0;
        D_md_start = 0; D_md_div = 0; D_md_use = 0;
        E_wa = '0; E_regwrite = 0; E_load = 0; M_wa = '0; M_load = 0;
    endtask

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl(input string tag, input logic exp_stall);
        chk({tag, "_stall"}, 32'(stall), 32'(exp_stall));
        chk({tag, "_pc_en"}, 32'(pc_en), 32'(!exp_stall));
        chk({tag, "_flush"}, 32'(flush_E), 32'(exp_stall));
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        // Hazard present during reset must not stall
        E_load = 1; E_wa = 5'd8; D_use_rs = 1; D_rs = 5'd8;
        #2;
        chk_ctrl("rst", 1'b0);
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_scnt", stall_cnt, 32'd0);
        tick();
        chk("rst_scnt_edge", stall_cnt, 32'd0);
        clear_inputs();
        reset = 1'b0;
        tick();

        // Load-use on rs
        E_load = 1; E_wa = 5'd8; D_use_rs = 1; D_rs = 5'd8;
        #1;
        chk_ctrl("lduse", 1'b1);
        tick();
        chk("lduse_scnt", stall_cnt, 32'd1);
        E_load = 0;
        #1;
        chk_ctrl("lduse_clr", 1'b0);
        tick();
        chk("lduse_scnt_hold", stall_cnt, 32'd1);

        // $0 never matches; mismatches and unused operands do not stall
        clear_inputs();
        E_load = 1; E_wa = 5'd0; D_rs = 5'd0; D_use_rs = 1;
        #1; chk("zero_reg", 32'(stall), 32'd0);
        E_wa = 5'd9; D_rs = 5'd8; D_rt = 5'd10; D_use_rt = 1;
        #1; chk("mismatch", 32'(stall), 32'd0);
        E_wa = 5'd10; D_use_rt = 0;
        #1; chk("rt_unused", 32'(stall), 32'd0);
        D_use_rt = 1;
        #1; chk("lduse_rt", 32'(stall), 32'd1);
        tick();
        chk("lduse_rt_scnt", stall_cnt, 32'd2);

        // Branch operand hazards
        clear_inputs();
        D_branch = 1; D_rt = 5'd3; E_regwrite = 1; E_wa = 5'd3;
        #1; chk_ctrl("br_e", 1'b1);
        tick();
        E_wa = 5'd5; M_load = 1; M_wa = 5'd3;
        #1; chk_ctrl("br_m", 1'b1);
        tick();
        chk("br_scnt", stall_cnt, 32'd4);
        M_load = 0;
        #1; chk_ctrl("br_clr", 1'b0);
        E_regwrite = 0; E_wa = 5'd3;
        #1; chk("br_e_nowrite", 32'(stall), 32'd0);
        D_branch = 0; E_regwrite = 1;
        #1; chk("nobranch", 32'(stall), 32'd0);
        tick();

        // Divide: busy 10 cycles, dependent mflo stalls for all of them
        clear_inputs();
        D_md_start = 1; D_md_div = 1; D_md_use = 1;
        #1; chk("div_start_stall", 32'(stall), 32'd0);
        chk("div_idle", 32'(md_busy), 32'd0);
        tick();
        D_md_start = 0; D_md_div = 0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("div_busy%0d", i), 32'(md_busy), 32'd1);
            chk($sformatf("div_stall%0d", i), 32'(stall), 32'd1);
            tick();
        end
        chk("div_done_busy", 32'(md_busy), 32'd0);
        chk("div_done_stall", 32'(stall), 32'd0);
        chk("div_scnt", stall_cnt, 32'd14);

        // Multiply: busy 5 cycles
        D_md_start = 1; D_md_div = 0; D_md_use = 1;
        #1; chk("mul_start_stall", 32'(stall), 32'd0);
        tick();
        D_md_start = 0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("mul_busy%0d", i), 32'(md_busy), 32'd1);
            chk($sformatf("mul_stall%0d", i), 32'(stall), 32'd1);
            tick();
        end
        chk("mul_done_busy", 32'(md_busy), 32'd0);
        chk("mul_scnt", stall_cnt, 32'd19);

        // Start blocked by a load-use hazard, accepted on the following edge
        clear_inputs();
        D_md_start = 1; D_md_use = 1;
        E_load = 1; E_wa = 5'd8; D_use_rs = 1; D_rs = 5'd8;
        #1; chk("blk_stall", 32'(stall), 32'd1);
        tick();
        chk("blk_not_busy", 32'(md_busy), 32'd0);
        chk("blk_scnt", stall_cnt, 32'd20);
        E_load = 0;
        #1; chk("blk_clear", 32'(stall), 32'd0);
        tick();
        chk("blk_accepted", 32'(md_busy), 32'd1);
        // Busy alone does not stall an instruction that does not use the unit
        clear_inputs();
        #1; chk("busy_no_use", 32'(stall), 32'd0);
        for (int i = 0; i < 5; i++) tick();
        chk("blk_drained", 32'(md_busy), 32'd0);

        // Reset in the middle of a divide
        D_md_start = 1; D_md_div = 1; D_md_use = 1;
        tick();
        D_md_start = 0; D_md_div = 0;
        for (int i = 0; i < 3; i++) tick();
        chk("mid_busy", 32'(md_busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(md_busy), 32'd0);
        chk("mid_rst_scnt", stall_cnt, 32'd0);
        chk_ctrl("mid_rst", 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_ctrl("post_rst", 1'b0);
        chk("post_rst_busy", 32'(md_busy), 32'd0);
        tick();
        chk("post_rst_scnt", stall_cnt, 32'd0);
        chk("post_rst_busy_edge", 32'(md_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/bubble controller for the 5-stage pipeline.
- Detects load-use hazards, branch-in-D operand hazards and multiply/divide-unit occupancy.
- Drives the freeze for PC and the D-stage pipeline register, and injects a bubble into the E-stage register.
- Tracks mult/div busy with an internal countdown and keeps a saturating stall-cycle performance counter.

Parameters:
MULT_LAT, 5, busy cycles after an accepted mult/multu
DIV_LAT, 10, busy cycles after an accepted div/divu
CNT_W, 4, width of busy countdown; must hold max(MULT_LAT, DIV_LAT)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
D_rs  input  5  rs field of instruction in D
D_rt  input  5  rt field of instruction in D
D_use_rs  input  1  D instruction reads rs in D or E
D_use_rt  input  1  D instruction reads rt in D or E
D_branch  input  1  D instruction is a branch/jr resolved in D
D_md_start  input  1  D instruction is mult/multu/div/divu
D_md_div  input  1  qualifies D_md_start: 1 = div family
D_md_use  input  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
E_wa  input  5  destination register of E instruction
E_regwrite  input  1  E instruction writes the register file
E_load  input  1  E instruction is a load
M_wa  input  5  destination register of M instruction
M_load  input  1  M instruction is a load
stall  output  1  freeze for D-stage pipeline register, 1 = hold
pc_en  output  1  PC write enable, = ~stall
flush_E  output  1  clear E-stage register (bubble), = stall
md_busy  output  1  mult/div unit occupied
stall_cnt  output  32  saturating count of stalled cycles

Behaviour:
- Match definition: for a register r, match_X(r) = (X_wa == r) && (r != 0). Register 0 never causes a hazard.
- Hazard conditions (all combinational, evaluated in the current cycle):
  - ld_use = E_load && ((D_use_rs && match_E(D_rs)) || (D_use_rt && match_E(D_rt))).
  - br_haz = D_branch && ((E_regwrite && (match_E(D_rs) || match_E(D_rt))) || (M_load && (match_M(D_rs) || match_M(D_rt)))).
  - md_haz = D_md_use && md_busy.
- Outputs: stall = (ld_use | br_haz | md_haz) && !reset; pc_en = !stall; flush_E = stall.
- Busy countdown (register cnt, CNT_W bits):
  - md_busy = (cnt != 0).
  - Start accepted at a clock edge when D_md_start && !stall. At that edge cnt loads DIV_LAT if D_md_div = 1, otherwise MULT_LAT.
  - Otherwise cnt decrements by 1 when non-zero and holds at 0.
  - md_busy is therefore high for exactly LAT cycles following the accepting edge.
  - A start while busy cannot be accepted, because D_md_use is asserted and md_haz stalls it; no overlap handling is needed.
- Stalled-start boundary: a start request stalled by ld_use or br_haz is not accepted and cnt is unchanged. It is accepted at the first edge where stall = 0.
- stall_cnt: increments by 1 at each edge where stall = 1; saturates at 32'hFFFFFFFF.
- Reset (asynchronous): cnt = 0 and stall_cnt = 0 immediately. While reset is high: stall = 0, pc_en = 1, flush_E = 0, md_busy = 0.
  - Reset asserted mid-busy aborts the countdown.
  - After deassertion, operation resumes from idle on the next edge.

Test Plan:
- Load-use: E_load=1, E_wa=8, D_use_rs=1, D_rs=8 -> stall=1, pc_en=0, flush_E=1 same cycle. Next cycle E_load=0 -> stall=0; stall_cnt=1.
- $0 and mismatch: E_load=1, E_wa=0, D_rs=0 -> stall=0. Also E_wa=9, D_rs=8, D_rt=10 -> stall=0.
- Branch: D_branch=1, D_rt=3, E_regwrite=1, E_wa=3 -> stall=1. Then M_load=1, M_wa=3 with E non-matching -> stall=1. Then M_load=0 -> stall=0.
- Divide: D_md_start=1, D_md_div=1 accepted -> md_busy high exactly 10 cycles. mflo (D_md_use=1) issued next cycle -> stall for 10 cycles, released when cnt reaches 0. Repeat with mult -> 5 cycles.
- Start blocked: D_md_start=1 with simultaneous ld_use -> cnt stays 0 that edge. Accepted the following edge once ld_use clears.
- Reset mid-busy: assert reset 3 cycles after a div start, asynchronously between edges -> md_busy=0 and stall_cnt=0 immediately. After release, stall=0 and pc_en=1.
